// File: rtl/imm_pkg.sv
// Shared definitions for the immediate-expansion stage: format select encodings
// and the default datapath width.
package imm_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    SEL_I = 3'b000,
    SEL_J = 3'b001,
    SEL_U = 3'b010,
    SEL_Z = 3'b011,
    SEL_S = 3'b100,
    SEL_B = 3'b111
  } imm_sel_e;

endpackage

// File: rtl/imm_expand.sv
// Combinational RISC-V immediate expansion from instruction word and format select.
// Optional feature: define IMM_STAGE_ZIMM_EN to decode select 011 as the CSR zimm.
module imm_expand
  import imm_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      sel,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  // Every format is first built as a 32-bit signed value, then widened once.
  logic signed [31:0] imm32;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    imm32   = '0;
    illegal = 1'b0;
    case (sel)
      SEL_I: imm32 = {{20{instr[31]}}, instr[31:20]};
      SEL_J: imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      SEL_U: imm32 = {instr[31:12], 12'h000};
      SEL_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      SEL_B: imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
`ifdef IMM_STAGE_ZIMM_EN
      // Bit 31 is zero here, so the sign extension below is a zero extension.
      SEL_Z: imm32 = {27'd0, instr[19:15]};
`endif
      default: illegal = 1'b1;
    endcase
  end

  assign imm = XLEN'(imm32);

endmodule

// File: rtl/imm_stage.sv
// Immediate-expansion pipeline stage: one output register plus one skid entry,
// valid/ready on both sides. Optional macro IMM_STAGE_ZIMM_EN enables the zimm format.
module imm_stage
  import imm_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_sel,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [XLEN-1:0]  out_target,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  target;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } entry_t;

  logic [XLEN-1:0] exp_imm;
  logic            exp_illegal;
  entry_t          incoming;
  entry_t          main_q;
  entry_t          skid_q;
  logic            main_valid;
  logic            skid_valid;
  logic            accept;
  logic            main_free;

  imm_expand #(.XLEN(XLEN)) u_expand (
    .instr   (in_instr),
    .sel     (in_sel),
    .imm     (exp_imm),
    .illegal (exp_illegal)
  );

  assign incoming = '{imm: exp_imm, target: in_pc + exp_imm, tag: in_tag, illegal: exp_illegal};

  // Depends only on the skid flag and reset, never on out_ready, so the
  // upstream ready path is cut at this stage.
  assign in_ready  = !skid_valid && !rst;
  assign accept    = in_valid && in_ready;
  assign main_free = !main_valid || out_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_free) begin
      if (skid_valid) begin
        main_q     <= skid_q;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_q     <= incoming;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
    end
  end

  // NOTE: the skid payload is qualified by skid_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (!main_free && accept) begin
      skid_q <= incoming;
    end
  end

  assign out_valid   = main_valid;
  assign out_imm     = main_q.imm;
  assign out_target  = main_q.target;
  assign out_tag     = main_q.tag;
  assign out_illegal = main_q.illegal;

endmodule

// File: doc/imm_stage.md
IMM_STAGE -- requirements
Module: imm_stage

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, datapath width (legal values 32, 64).
REQ-002 The block SHALL have parameter TAG_W, default 4, sideband tag width.
REQ-003 The block SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-005 The block SHALL have port flush, input, 1, synchronous discard of all held entries.
REQ-006 The block SHALL have ports in_valid (input, 1) and in_ready (output, 1), the upstream handshake.
REQ-007 The block SHALL have ports in_instr (input, 32) instruction word, in_sel (input, 3) immediate format select, in_pc (input, XLEN) instruction address, and in_tag (input, TAG_W) opaque tag.
REQ-008 The block SHALL have ports out_valid (output, 1) and out_ready (input, 1), the downstream handshake.
REQ-009 The block SHALL have outputs out_imm (XLEN) expanded immediate, out_target (XLEN) pc+imm, out_tag (TAG_W), and out_illegal (1) unsupported select.

Function
REQ-010 in_sel encodings SHALL be: 000 I {instr[31:20]}; 001 J {instr[31],instr[19:12],instr[20],instr[30:21],0}; 010 U {instr[31:12],12'h0}; 100 S {instr[31:25],instr[11:7]}; 111 B {instr[31],instr[7],instr[30:25],instr[11:8],0}.
REQ-011 I/J/S/B immediates SHALL be sign-extended from their MSB to XLEN, and U SHALL be sign-extended from bit 31 when XLEN=64.
REQ-012 Unsupported encodings SHALL give out_imm=0 and out_illegal=1; supported encodings SHALL give out_illegal=0.
REQ-013 out_target SHALL equal in_pc+out_imm modulo 2^XLEN for every encoding.
REQ-014 Storage SHALL be one main output register plus one skid entry; a transfer occurs on valid&&ready.
REQ-015 Latency SHALL be 1 cycle: an entry accepted at edge N appears on outputs after edge N when the main register is empty or draining.
REQ-016 in_ready SHALL equal !skid_valid, driven from a register with no combinational path from out_ready.
REQ-017 On accept when main is full and out_ready=0, the entry SHALL go to skid.
REQ-018 When main drains, it SHALL load skid if skid is valid, else the new accepted entry, else become empty.
REQ-019 Sustained throughput SHALL be 1 entry/cycle with out_ready=1, order SHALL be strictly FIFO, and there SHALL be no loss or duplication.
REQ-020 Outputs SHALL be held stable while out_valid=1 and out_ready=0.
REQ-021 Flush SHALL invalidate main and skid at the next edge, discard any same-cycle accepted entry, and dominate accept and drain.

Reset
REQ-022 While rst=1, at the next edge out_valid, skid_valid, out_imm, out_target, out_tag and out_illegal SHALL become 0.
REQ-023 in_ready SHALL be 0 while rst=1 and 1 in the first cycle after rst deasserts.
REQ-024 Reset asserted mid-transfer SHALL drop all held entries with no partial output.

Configuration
REQ-025 With IMM_STAGE_ZIMM_EN defined, encoding 011 SHALL produce the CSR zimm, instr[19:15] zero-extended to XLEN, with out_illegal=0.
REQ-026 Without IMM_STAGE_ZIMM_EN, encoding 011 SHALL be treated as unsupported per REQ-012.

Structure
REQ-027 Package imm_pkg SHALL hold the imm_sel_e enum (the six encodings) and the XLEN default constant.
REQ-028 The combinational format expansion SHALL be sub-module imm_expand (instr, sel -> imm, illegal), instantiated once ahead of the register stage.

Verification
REQ-029 XLEN=32, I, instr 0xFFF00093, out_ready=1 -> next cycle out_imm 0xFFFFFFFF, out_illegal 0.
REQ-030 B, instr 0xFE000EE3, pc 0x00000100 -> out_imm 0xFFFFFFFC, out_target 0x000000FC.
REQ-031 XLEN=64, U, instr 0x800002B7 -> out_imm 0xFFFFFFFF80000000.
REQ-032 Tags 1,2,3 sent back-to-back with out_ready=0 for 2 cycles -> in_ready falls after skid fills; outputs arrive in order 1,2,3 with none lost.
REQ-033 Main and skid full, flush=1 with in_valid=1 -> next cycle out_valid 0, in_ready 1, and the flushed input never appears.
REQ-034 sel 101 -> out_imm 0, out_illegal 1; sel 011 with instr[19:15]=0x1F -> out_imm 0x1F when IMM_STAGE_ZIMM_EN is defined, illegal otherwise.
